// File: rtl/ysyx_25060170_ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response bus plus the decode
// and write-back handshakes. master = fetch unit, slave = memory/decode side.
interface ysyx_25060170_ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_err;
    logic [31:0] imem_rdata;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        wb_valid_i;
    logic        jump_en_i;
    logic [31:0] jump_pc_i;

    modport master (
        output imem_req_valid, imem_addr, inst_valid_o, pc_o, inst_o,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_err, imem_rdata,
        input  id_ready_i, wb_valid_i, jump_en_i, jump_pc_i
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid_o, pc_o, inst_o,
        output imem_req_ready, imem_rsp_valid, imem_rsp_err, imem_rdata,
        output id_ready_i, wb_valid_i, jump_en_i, jump_pc_i
    );
endinterface

// File: rtl/ysyx_25060170_ifu_fetch.sv
// Non-pipelined instruction fetch: owns the PC, fetches one word, hands it to
// decode and waits for retire. Optional macro IFU_ALIGN_CHK_EN faults misaligned PCs.
//
// state  | meaning
// S_IDLE | dead cycle after reset release
// S_REQ  | request at pc on imem, held until accepted
// S_WAIT | request accepted, waiting for the response
// S_OUT  | {pc, inst} offered to decode
// S_EXEC | decode owns the instruction, waiting for retire
module ysyx_25060170_ifu_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic                             clk,
    input  logic                             rst_n,
    ysyx_25060170_ifu_fetch_if.master        bus,
    output logic                             fetch_fault_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_EXEC
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic        misalign;

`ifdef IFU_ALIGN_CHK_EN
    assign misalign = (pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                // a misaligned PC never reaches the bus; it goes straight to decode as a trap
                if (misalign) begin
                    state_nxt = S_OUT;
                end else if (bus.imem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (bus.imem_rsp_valid) state_nxt = S_OUT;
            S_OUT:  if (bus.id_ready_i)     state_nxt = S_EXEC;
            S_EXEC: if (bus.wb_valid_i)     state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = (state == S_REQ) && !misalign;
        bus.inst_valid_o   = (state == S_OUT);
    end

    assign bus.imem_addr  = pc;
    assign bus.pc_o       = pc;
    assign bus.inst_o     = inst;
    assign fetch_fault_o  = fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            inst  <= 32'd0;
            fault <= 1'b0;
        end else begin
            if (state == S_WAIT && bus.imem_rsp_valid) begin
                inst <= bus.imem_rsp_err ? EBREAK_INST : bus.imem_rdata;
                if (bus.imem_rsp_err) begin
                    fault <= 1'b1;
                end
            end
            if (state == S_REQ && misalign) begin
                inst  <= EBREAK_INST;
                fault <= 1'b1;
            end
            if (state == S_EXEC && bus.wb_valid_i) begin
                pc <= bus.jump_en_i ? (bus.jump_pc_i & 32'hFFFF_FFFE) : pc + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// Directed bench for the fetch stage: a transaction-level model of PC/inst/fault
// checked every cycle, plus literal expectations at key points.
module tb_ysyx_25060170_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fetch_fault_o;

    ysyx_25060170_ifu_fetch_if bus();

    ysyx_25060170_ifu_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .fetch_fault_o (fetch_fault_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int valid_cyc = 0;
    int n_req_dut = 0;
    int n_req_exp = 0;

    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_inst = 32'd0;
    logic        exp_out = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_fault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h8050_0093;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (bus.imem_req_valid && bus.imem_req_ready) n_req_dut++;
    end

    always @(negedge clk) begin
        chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", bus.imem_addr, exp_pc);
        chk("inst_valid", {31'b0, bus.inst_valid_o}, {31'b0, exp_out});
        if (exp_out) begin
            chk("pc_o", bus.pc_o, exp_pc);
            chk("inst_o", bus.inst_o, exp_inst);
        end
        chk("fault", {31'b0, fetch_fault_o}, {31'b0, exp_fault});
    end

    task automatic wait_for(input int sel, input string name);
        int  n = 0;
        logic hit = 1'b0;
        while (!hit && n < 50) begin
            @(negedge clk);
            n++;
            hit = (sel == 0) ? bus.imem_req_valid : bus.inst_valid_o;
        end
        chk(name, {31'b0, hit}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_pc = RESET_PC; exp_inst = 32'd0; exp_out = 1'b0; exp_req = 1'b0; exp_fault = 1'b0;
        @(negedge clk);
        chk("rst_pc", bus.pc_o, RESET_PC);
        chk("rst_inst", bus.inst_o, 32'd0);
        chk("rst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("rst_req", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_fault", {31'b0, fetch_fault_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rel_cyc = cyc;
        // stale response arriving after release must be dropped
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        exp_req = 1'b1;
    endtask

    task automatic serve_req(input int stall, input bit spurious_wb);
        wait_for(0, "req_seen");
        repeat (stall) begin
            bus.imem_req_ready = 1'b0;
            if (spurious_wb) begin
                bus.wb_valid_i = 1'b1; bus.jump_en_i = 1'b1; bus.jump_pc_i = 32'h1234_5670;
            end
            @(negedge clk);
        end
        bus.wb_valid_i = 1'b0; bus.jump_en_i = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        exp_req = 1'b0;
        n_req_exp++;
        chk("req_count", n_req_dut, n_req_exp);
    endtask

    task automatic serve_rsp(input int delay, input bit err);
        repeat (delay) begin @(posedge clk); #1; end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err = err;
        bus.imem_rdata = err ? 32'h1234_5678 : mem_word(exp_pc);
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        exp_inst = err ? EBREAK : mem_word(exp_pc);
        exp_fault = exp_fault | err;
        exp_out = 1'b1;
    endtask

    task automatic decode_accept(input int delay);
        wait_for(1, "valid_seen");
        valid_cyc = cyc - rel_cyc + 1;
        repeat (delay) begin
            bus.id_ready_i = 1'b0;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
        end
        bus.imem_rsp_valid = 1'b0;
        bus.id_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.id_ready_i = 1'b0;
        exp_out = 1'b0;
    endtask

    task automatic retire(input int delay, input bit jump, input logic [31:0] jpc);
        repeat (delay) begin
            bus.jump_en_i = 1'b1; bus.jump_pc_i = 32'h0BAD_0BAD;
            @(negedge clk);
        end
        bus.wb_valid_i = 1'b1; bus.jump_en_i = jump; bus.jump_pc_i = jpc;
        @(posedge clk); #1;
        bus.wb_valid_i = 1'b0; bus.jump_en_i = 1'b0; bus.jump_pc_i = 32'hFFFF_FFFF;
        exp_pc = jump ? (jpc & ~32'h1) : exp_pc + 32'd4;
`ifdef IFU_ALIGN_CHK_EN
        if (exp_pc[1:0] != 2'b00) begin
            exp_req = 1'b0;
            @(posedge clk); #1;
            exp_inst = EBREAK; exp_fault = 1'b1; exp_out = 1'b1;
        end else begin
            exp_req = 1'b1;
        end
`else
        exp_req = 1'b1;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_err = 1'b0;
        bus.imem_rdata = 32'd0; bus.id_ready_i = 1'b0; bus.wb_valid_i = 1'b0;
        bus.jump_en_i = 1'b0; bus.jump_pc_i = 32'd0;
        do_reset();

        // first fetch after reset
        serve_req(0, 0);
        serve_rsp(0, 0);
        decode_accept(0);
        chk("t1_valid_cycle", valid_cyc, 32'd4);
        chk("t1_pc", bus.pc_o, 32'h8000_0000);
        chk("t1_inst", bus.inst_o, 32'h0050_0093);

        // sequential and jump redirects
        retire(2, 0, 32'd0);
        chk("t2_seq_addr", bus.imem_addr, 32'h8000_0004);
        serve_req(0, 0);
        serve_rsp(1, 0);
        decode_accept(0);
        retire(0, 1, 32'h8000_0101);
        chk("t2_jump_addr", bus.imem_addr, 32'h8000_0100);
        serve_req(0, 0);
        serve_rsp(0, 0);

        // backpressure on both handshakes, early id_ready
        decode_accept(3);
        retire(1, 0, 32'd0);
        serve_req(5, 0);
        serve_rsp(2, 0);
        bus.id_ready_i = 1'b1;
        decode_accept(0);
        chk("t3_pc", bus.pc_o, 32'h8000_0104);

        // errored fetch, then pc wrap
        retire(0, 1, 32'hFFFF_FFFC);
        serve_req(0, 0);
        serve_rsp(0, 1);
        decode_accept(0);
        chk("t4_inst", bus.inst_o, 32'h0010_0073);
        chk("t4_fault", {31'b0, fetch_fault_o}, 32'd1);
        retire(0, 0, 32'd0);
        chk("t4_wrap_addr", bus.imem_addr, 32'h0000_0000);
        serve_req(0, 0);
        serve_rsp(0, 0);
        decode_accept(1);
        chk("t4_fault_sticky", {31'b0, fetch_fault_o}, 32'd1);

        // reset mid-wait, spurious retire during request
        retire(0, 0, 32'd0);
        serve_req(0, 0);
        do_reset();
        serve_req(3, 1);
        chk("t5_addr", bus.imem_addr, 32'h8000_0000);
        serve_rsp(0, 0);
        decode_accept(0);
        chk("t5_pc", bus.pc_o, 32'h8000_0000);
        chk("t5_inst", bus.inst_o, 32'h0050_0093);

        // misaligned redirect target
        retire(0, 1, 32'h8000_0102);
`ifdef IFU_ALIGN_CHK_EN
        chk("t6_inst", bus.inst_o, 32'h0010_0073);
        chk("t6_fault", {31'b0, fetch_fault_o}, 32'd1);
        chk("t6_valid", {31'b0, bus.inst_valid_o}, 32'd1);
        decode_accept(0);
        retire(0, 1, 32'h8000_0200);
        serve_req(0, 0);
        serve_rsp(0, 0);
        decode_accept(0);
`else
        chk("t6_addr", bus.imem_addr, 32'h8000_0102);
        serve_req(0, 0);
        serve_rsp(0, 0);
        decode_accept(0);
        chk("t6_inst", bus.inst_o, 32'h0050_0193);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
